uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmit path: takes a parallel byte plus frame config and shifts out one
//   frame (start, DATA_WIDTH data bits LSB-first, optional parity, stop), one bit
//   per CLK cycle. CLK is the TX bit-rate clock. Transmit counterpart of the UART RX
//   deserializer; output frames match what the RX path samples.
// PARAMETERS
//   DATA_WIDTH   8   payload bits per frame
// PORTS
//   CLK          in   1            TX bit clock, all logic on posedge
//   RST          in   1            synchronous, active-high reset
//   P_DATA       in   DATA_WIDTH   parallel byte to send
//   Data_Valid   in   1            single-cycle request to send P_DATA
//   PAR_EN       in   1            1 = insert parity bit
//   PAR_TYP      in   1            0 = even, 1 = odd parity
//   TX_OUT       out  1            serial line, idle high
//   Busy         out  1            1 while a frame is on the line
// BEHAVIOUR
//   - Reset (RST=1 at posedge): state IDLE, TX_OUT=1, Busy=0, shift reg=0, bit_cnt=0,
//     latched config=0; reset overrides any request or frame in flight that cycle.
//   - All outputs registered. FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept: Data_Valid=1 in IDLE -> capture P_DATA, PAR_EN, PAR_TYP. Next cycle:
//     state START, TX_OUT=0, Busy=1 (1-cycle latency, accept to start bit).
//   - START: 1 cycle -> DATA. DATA: DATA_WIDTH cycles, TX_OUT=shift[0], shift right;
//     bit_cnt 0..DATA_WIDTH-1, leaves DATA when bit_cnt==DATA_WIDTH-1, wraps to 0.
//   - PARITY (only if latched PAR_EN): 1 cycle, TX_OUT = ^data ^ PAR_TYP
//     (even: total ones incl. parity even; odd: odd).
//   - STOP: 1 cycle, TX_OUT=1, then IDLE with Busy=0. Frame = 10 cycles (no parity)
//     or 11 cycles (parity) for DATA_WIDTH=8.
//   - Data_Valid while Busy=1: ignored (see CONFIGURATION). Data_Valid in the IDLE
//     cycle after STOP accepted normally: min 1 idle-high cycle between frames.
//   - P_DATA/PAR_EN/PAR_TYP changes mid-frame: no effect on current frame.
//   - Data_Valid held high: re-triggers each time IDLE is reached.
// CONFIGURATION
//   UART_TX_HOLD_BUF_EN defined: one-entry holding register (data + config).
//     Data_Valid while Busy=1 and holding empty -> captured. On STOP with holding
//     full -> go directly to START with held frame (no idle cycle), holding cleared.
//     Data_Valid while Busy=1 and holding full -> dropped, holding unchanged.
//     Data_Valid in the STOP cycle of the last frame -> written to holding, sent next.
//     Reset clears holding valid.
//   Not defined: no holding register; Data_Valid while Busy=1 dropped; no area cost.
// TESTING
//   1. Reset then idle 5 cycles -> TX_OUT=1, Busy=0 throughout.
//   2. P_DATA=0xA5, PAR_EN=0, Data_Valid pulse -> TX_OUT 0,1,0,1,0,0,1,0,1,1;
//      Busy high exactly 10 cycles.
//   3. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> 0,1,0,1,0,0,1,0,1,0,1 (11 cycles);
//      repeat PAR_TYP=1 -> parity bit=1.
//   4. P_DATA=0x01, PAR_EN=1, PAR_TYP=0 -> parity 1; change P_DATA to 0xFF and
//      PAR_TYP to 1 at data bit 3 -> frame unchanged.
//   5. Send 0x3C; pulse Data_Valid with 0xC3 at data bit 4 -> without macro: 0xC3
//      never sent, line idle after stop; with UART_TX_HOLD_BUF_EN: 0xC3 start bit
//      immediately after 0x3C stop bit; third pulse while holding full -> dropped.
//   6. RST=1 during data bit 5 of 0xFF -> next cycle TX_OUT=1, Busy=0; following
//      Data_Valid with 0x55 -> clean full frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   UART transmit serializer. Accepts a parallel word plus frame configuration
//   and shifts out one frame per request, one bit per CLK cycle:
//     start (0), DATA_WIDTH data bits LSB first, optional parity, stop (1).
//   CLK is the transmit bit-rate clock. The line idles high.
//
// Optional feature:
//   UART_TX_HOLD_BUF_EN - when defined, adds a one-entry holding register so a
//   request arriving while a frame is on the line is queued and launched
//   back-to-back (no idle cycle) after the current stop bit. When undefined,
//   requests made while busy are dropped.
//
// Ports:
//   CLK         in   1           transmit bit clock, all logic on posedge
//   RST         in   1           synchronous active-high reset
//   P_DATA      in   DATA_WIDTH  parallel word to send
//   Data_Valid  in   1           single-cycle request to send P_DATA
//   PAR_EN      in   1           1 = append a parity bit
//   PAR_TYP     in   1           0 = even parity, 1 = odd parity
//   TX_OUT      out  1           serial line (registered), idle high
//   Busy        out  1           high while a frame is on the line (registered)
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
      return (^data) ^ odd;
   endfunction

   state_t                state_q,   state_d;
   logic [DATA_WIDTH-1:0] shift_q,   shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  par_en_q,  par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  tx_out_q,  tx_out_d;
   logic                  busy_q,    busy_d;

`ifdef UART_TX_HOLD_BUF_EN
   logic [DATA_WIDTH-1:0] hold_data_q,    hold_data_d;
   logic                  hold_par_en_q,  hold_par_en_d;
   logic                  hold_par_bit_q, hold_par_bit_d;
   logic                  hold_vld_q,     hold_vld_d;
`endif

   // Next-state and next-output logic; outputs are computed for the state
   // being entered so the registered line reflects the new state directly.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      tx_out_d  = 1'b1;
      busy_d    = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
      hold_data_d    = hold_data_q;
      hold_par_en_d  = hold_par_en_q;
      hold_par_bit_d = hold_par_bit_q;
      hold_vld_d     = hold_vld_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (Data_Valid) begin
               state_d   = ST_START;
               shift_d   = P_DATA;
               par_en_d  = PAR_EN;
               par_bit_d = parity_bit(P_DATA, PAR_TYP);
               tx_out_d  = 1'b0;
               busy_d    = 1'b1;
            end else begin
               tx_out_d  = 1'b1;
               busy_d    = 1'b0;
            end
         end

         ST_START: begin
            // First data bit goes out now; the shifter then exposes the next one.
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            tx_out_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            busy_d    = 1'b1;
         end

         ST_DATA: begin
            busy_d = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               if (par_en_q) begin
                  state_d  = ST_PARITY;
                  tx_out_d = par_bit_q;
               end else begin
                  state_d  = ST_STOP;
                  tx_out_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               tx_out_d  = shift_q[0];
               shift_d   = shift_q >> 1;
            end
         end

         ST_PARITY: begin
            state_d  = ST_STOP;
            tx_out_d = 1'b1;
            busy_d   = 1'b1;
         end

         ST_STOP: begin
`ifdef UART_TX_HOLD_BUF_EN
            // A queued frame (or one requested right now) starts with no idle gap.
            if (hold_vld_q) begin
               state_d    = ST_START;
               shift_d    = hold_data_q;
               par_en_d   = hold_par_en_q;
               par_bit_d  = hold_par_bit_q;
               hold_vld_d = 1'b0;
               tx_out_d   = 1'b0;
               busy_d     = 1'b1;
            end else if (Data_Valid) begin
               state_d   = ST_START;
               shift_d   = P_DATA;
               par_en_d  = PAR_EN;
               par_bit_d = parity_bit(P_DATA, PAR_TYP);
               tx_out_d  = 1'b0;
               busy_d    = 1'b1;
            end else begin
               state_d  = ST_IDLE;
               tx_out_d = 1'b1;
               busy_d   = 1'b0;
            end
`else
            state_d  = ST_IDLE;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
`endif
         end

         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tx_out_d  = 1'b1;
            busy_d    = 1'b0;
         end
      endcase

`ifdef UART_TX_HOLD_BUF_EN
      // Requests mid-frame fill an empty holding slot; STOP is handled above.
      if (Data_Valid && !hold_vld_q && (state_q != ST_IDLE) && (state_q != ST_STOP)) begin
         hold_data_d    = P_DATA;
         hold_par_en_d  = PAR_EN;
         hold_par_bit_d = parity_bit(P_DATA, PAR_TYP);
         hold_vld_d     = 1'b1;
      end else begin
         hold_vld_d     = hold_vld_d;
      end
`endif
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
         hold_data_q    <= '0;
         hold_par_en_q  <= 1'b0;
         hold_par_bit_q <= 1'b0;
         hold_vld_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
`ifdef UART_TX_HOLD_BUF_EN
         hold_data_q    <= hold_data_d;
         hold_par_en_q  <= hold_par_en_d;
         hold_par_bit_q <= hold_par_bit_d;
         hold_vld_q     <= hold_vld_d;
`endif
      end
   end

   assign TX_OUT = tx_out_q;
   assign Busy   = busy_q;

endmodule
